// File: rtl/usb_fs_out_sequencer.sv
// USB full-speed OUT/SETUP receive sequencer.
// Accepts tokens addressed to this device and steers the following data
// packet to an OUT endpoint. The two trailing CRC16 bytes are held back in
// a 2-deep byte pipeline so they never reach the endpoint. Per-endpoint data
// toggles are tracked here, and one ACK/NAK/STALL request goes out per
// transaction.
module usb_fs_out_sequencer #(
  parameter int NUM_EP      = 4,
  parameter int MAX_PKT     = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        dev_addr,
  input  logic              rx_pkt_start,
  input  logic              rx_pkt_end,
  input  logic [3:0]        rx_pid,
  input  logic [6:0]        rx_addr,
  input  logic [3:0]        rx_endp,
  input  logic              rx_valid_packet,
  input  logic              rx_data_put,
  input  logic [7:0]        rx_data,
  input  logic [NUM_EP-1:0] ep_ready,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic [NUM_EP-1:0] toggle_clr,
  output logic [3:0]        ep_num,
  output logic              ep_data_put,
  output logic [7:0]        ep_data,
  output logic              ep_commit,
  output logic              ep_abort,
  output logic              ep_setup,
  output logic              hs_req,
  output logic [3:0]        hs_pid,
  input  logic              hs_ack
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam int EPW   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int CNT_W = $clog2(MAX_PKT + 3) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [4:0]       EP_LIM  = 5'(NUM_EP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] OVF_LIM = CNT_W'(MAX_PKT + 2);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, DATA, HANDSHAKE} state_t;

  state_t             r_state;
  logic [EPW-1:0]     r_ep;
  logic               r_is_setup;
  logic               r_rdy;
  logic               r_stl;
  logic [TMO_W-1:0]   r_tmo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [1:0]         r_pcnt;
  logic [7:0]         r_pipe0;
  logic [7:0]         r_pipe1;
  logic [NUM_EP-1:0]  r_toggle;
  logic               r_ep_data_put;
  logic [7:0]         r_ep_data;
  logic               r_commit;
  logic               r_abort;
  logic               r_setup_o;
  logic               r_hs_req;
  logic [3:0]         r_hs_pid;

  logic [EPW-1:0]     w_idx;
  logic               w_tok_ok;
  logic               w_is_data;
  logic               w_dec;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_emit;
  logic               w_commit;
  logic               w_abort;
  logic               w_hs;
  logic [3:0]         w_hs_pid;
  logic               w_tog_wr;
  logic               w_tog_val;
  logic [NUM_EP-1:0]  w_tog_mask;

  assign w_idx     = rx_endp[EPW-1:0];
  assign w_tok_ok  = rx_pkt_end && rx_valid_packet &&
                     ((rx_pid == PID_OUT) || (rx_pid == PID_SETUP)) &&
                     (rx_addr == dev_addr) && ({1'b0, rx_endp} < EP_LIM);
  assign w_is_data = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
  assign w_dec     = (r_state == DATA) && rx_pkt_end;
  assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  // A byte leaves the pipeline only once two newer bytes sit behind it, so
  // the final two (CRC) bytes are never emitted.
  assign w_emit    = rx_data_put && (r_pcnt == 2'd2) && !r_ovf &&
                     (w_cnt_nxt <= OVF_LIM);

  // Transaction outcome at the end of the data packet; first match wins.
  always_comb begin
    w_commit  = 1'b0;
    w_abort   = 1'b0;
    w_hs      = 1'b0;
    w_hs_pid  = PID_ACK;
    w_tog_wr  = 1'b0;
    w_tog_val = 1'b0;
    if (!rx_valid_packet || !w_is_data || r_ovf) begin
      w_abort = 1'b1;
    end else if (r_is_setup) begin
      if (rx_pid[3]) begin
        w_abort = 1'b1;
      end else begin
        w_commit  = 1'b1;
        w_hs      = 1'b1;
        w_tog_wr  = 1'b1;
        w_tog_val = 1'b1;
      end
    end else if (r_stl) begin
      w_abort  = 1'b1;
      w_hs     = 1'b1;
      w_hs_pid = PID_STALL;
    end else if (!r_rdy) begin
      w_abort  = 1'b1;
      w_hs     = 1'b1;
      w_hs_pid = PID_NAK;
    end else if (rx_pid[3] != r_toggle[r_ep]) begin
      w_abort = 1'b1;
      w_hs    = 1'b1;
    end else begin
      w_commit  = 1'b1;
      w_hs      = 1'b1;
      w_tog_wr  = 1'b1;
      w_tog_val = ~r_toggle[r_ep];
    end
  end

  assign w_tog_mask = (w_dec && w_tog_wr) ? (NUM_EP'(1) << r_ep) : '0;

  // Data toggles; an explicit clear overrides a same-cycle update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_toggle <= '0;
    end else begin
      r_toggle <= ((r_toggle & ~w_tog_mask) | (w_tog_val ? w_tog_mask : '0)) &
                  ~toggle_clr;
    end
  end

  // Transaction FSM with the CRC-strip pipeline and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_ep          <= '0;
      r_is_setup    <= 1'b0;
      r_rdy         <= 1'b0;
      r_stl         <= 1'b0;
      r_tmo         <= '0;
      r_cnt         <= '0;
      r_ovf         <= 1'b0;
      r_pcnt        <= '0;
      r_pipe0       <= '0;
      r_pipe1       <= '0;
      r_ep_data_put <= 1'b0;
      r_ep_data     <= '0;
      r_commit      <= 1'b0;
      r_abort       <= 1'b0;
      r_setup_o     <= 1'b0;
      r_hs_req      <= 1'b0;
      r_hs_pid      <= '0;
    end else begin
      r_ep_data_put <= 1'b0;
      r_commit      <= 1'b0;
      r_abort       <= 1'b0;
      r_setup_o     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tok_ok) begin
            r_ep       <= w_idx;
            r_is_setup <= (rx_pid == PID_SETUP);
            r_rdy      <= ep_ready[w_idx];
            r_stl      <= ep_stall[w_idx];
            r_tmo      <= '0;
            r_state    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (rx_pkt_start) begin
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_pcnt  <= '0;
            r_state <= DATA;
          end else if (r_tmo == TMO_LIM) begin
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        DATA: begin
          if (rx_data_put) begin
            r_pipe0 <= rx_data;
            r_pipe1 <= r_pipe0;
            r_cnt   <= w_cnt_nxt;
            if (r_pcnt != 2'd2) r_pcnt <= r_pcnt + 1'b1;
            if (w_cnt_nxt > OVF_LIM) r_ovf <= 1'b1;
            if (w_emit) begin
              r_ep_data_put <= 1'b1;
              r_ep_data     <= r_pipe1;
            end
          end
          if (rx_pkt_end) begin
            r_commit  <= w_commit;
            r_abort   <= w_abort;
            r_setup_o <= w_commit && r_is_setup;
            if (w_hs) begin
              r_hs_req <= 1'b1;
              r_hs_pid <= w_hs_pid;
              r_state  <= HANDSHAKE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        HANDSHAKE: begin
          if (r_hs_req && hs_ack) begin
            r_hs_req <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ep_num      = 4'(r_ep);
  assign ep_data_put = r_ep_data_put;
  assign ep_data     = r_ep_data;
  assign ep_commit   = r_commit;
  assign ep_abort    = r_abort;
  assign ep_setup    = r_setup_o;
  assign hs_req      = r_hs_req;
  assign hs_pid      = r_hs_pid;

endmodule

// File: tb/tb_usb_fs_out_sequencer.sv
// Directed bench for usb_fs_out_sequencer: a transaction table plus
// hand-written sequences for toggle clear, timeout edges and reset.
`timescale 1ns/1ps
module tb_usb_fs_out_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] dev_addr = 7'd5;
  logic       rx_pkt_start = 1'b0;
  logic       rx_pkt_end = 1'b0;
  logic [3:0] rx_pid = '0;
  logic [6:0] rx_addr = '0;
  logic [3:0] rx_endp = '0;
  logic       rx_valid_packet = 1'b0;
  logic       rx_data_put = 1'b0;
  logic [7:0] rx_data = '0;
  logic [3:0] ep_ready = '0;
  logic [3:0] ep_stall = '0;
  logic [3:0] toggle_clr = '0;
  logic [3:0] ep_num;
  logic       ep_data_put;
  logic [7:0] ep_data;
  logic       ep_commit;
  logic       ep_abort;
  logic       ep_setup;
  logic       hs_req;
  logic [3:0] hs_pid;
  logic       hs_ack = 1'b1;

  usb_fs_out_sequencer #(.NUM_EP(4), .MAX_PKT(64), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .reset_n(reset_n), .dev_addr(dev_addr),
    .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .rx_pid(rx_pid),
    .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_valid_packet(rx_valid_packet),
    .rx_data_put(rx_data_put), .rx_data(rx_data), .ep_ready(ep_ready),
    .ep_stall(ep_stall), .toggle_clr(toggle_clr), .ep_num(ep_num),
    .ep_data_put(ep_data_put), .ep_data(ep_data), .ep_commit(ep_commit),
    .ep_abort(ep_abort), .ep_setup(ep_setup), .hs_req(hs_req),
    .hs_pid(hs_pid), .hs_ack(hs_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Output monitor, sampled on the falling edge.
  logic [7:0] got[$];
  int   c_commit = 0, c_abort = 0, c_setup = 0, c_hs = 0, c_both = 0;
  logic [3:0] last_pid = '0;
  logic prev_hs = 1'b0;

  always @(negedge clk) begin
    if (ep_data_put) got.push_back(ep_data);
    if (ep_commit) c_commit++;
    if (ep_abort) c_abort++;
    if (ep_setup) c_setup++;
    if (ep_commit && ep_abort) c_both++;
    if (hs_req && !prev_hs) begin
      c_hs++;
      last_pid = hs_pid;
    end
    prev_hs = hs_req;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got.delete();
    c_commit = 0; c_abort = 0; c_setup = 0; c_hs = 0;
  endtask

  // Caller sits at a falling edge; returns at a falling edge.
  task automatic token(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e);
    rx_pkt_end = 1'b1; rx_pid = pid; rx_addr = a; rx_endp = e; rx_valid_packet = 1'b1;
    @(negedge clk);
    rx_pkt_end = 1'b0; rx_valid_packet = 1'b0;
  endtask

  task automatic data_pkt(input logic [3:0] pid, input int nb, input logic dval,
                          input logic [7:0] base, input logic [3:0] clr);
    rx_pkt_start = 1'b1;
    @(negedge clk);
    rx_pkt_start = 1'b0;
    for (int k = 0; k < nb; k++) begin
      rx_data_put = 1'b1; rx_data = 8'(int'(base) + k);
      @(negedge clk);
    end
    rx_data_put = 1'b0;
    rx_pkt_end = 1'b1; rx_pid = pid; rx_valid_packet = dval; toggle_clr = clr;
    @(negedge clk);
    rx_pkt_end = 1'b0; rx_valid_packet = 1'b0; toggle_clr = '0;
  endtask

  task automatic run_txn(input logic [3:0] tpid, input logic [6:0] a, input logic [3:0] e,
                         input logic rdy, input logic stl, input logic [3:0] dpid,
                         input int nb, input logic dval, input logic [7:0] base,
                         input logic [3:0] clr);
    ep_ready = rdy ? 4'hF : 4'h0;
    ep_stall = stl ? 4'hF : 4'h0;
    clear_mon();
    token(tpid, a, e);
    data_pkt(dpid, nb, dval, base, clr);
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] tpid; logic [6:0] addr; logic [3:0] endp;
    logic rdy; logic stl; logic [3:0] dpid; int nb; logic dval;
    int ec; int ea; int eh; logic [3:0] epid; int es; int enb; int epn;
  } vec_t;

  vec_t vt[17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          tpid  addr  ep  rdy stl dpid  nb  dv  ec ea eh epid  es enb epn
    vt[0]  = '{4'h1, 7'd5, 4'd1, 1, 0, 4'h3,  6, 1,  1, 0, 1, 4'h2, 0,  4,  1};
    vt[1]  = '{4'h1, 7'd5, 4'd1, 1, 0, 4'h3,  6, 1,  0, 1, 1, 4'h2, 0,  4,  1};
    vt[2]  = '{4'h1, 7'd5, 4'd1, 1, 0, 4'hB,  6, 1,  1, 0, 1, 4'h2, 0,  4,  1};
    vt[3]  = '{4'h1, 7'd5, 4'd2, 1, 1, 4'h3,  6, 1,  0, 1, 1, 4'hE, 0,  4,  2};
    vt[4]  = '{4'h1, 7'd5, 4'd2, 0, 0, 4'h3,  6, 1,  0, 1, 1, 4'hA, 0,  4,  2};
    vt[5]  = '{4'h1, 7'd5, 4'd2, 1, 0, 4'h3,  6, 1,  1, 0, 1, 4'h2, 0,  4,  2};
    vt[6]  = '{4'hD, 7'd5, 4'd0, 0, 1, 4'h3, 10, 1,  1, 0, 1, 4'h2, 1,  8,  0};
    vt[7]  = '{4'h1, 7'd5, 4'd0, 1, 0, 4'hB,  6, 1,  1, 0, 1, 4'h2, 0,  4,  0};
    vt[8]  = '{4'h1, 7'd6, 4'd0, 1, 0, 4'h3,  6, 1,  0, 0, 0, 4'h0, 0,  0, -1};
    vt[9]  = '{4'h1, 7'd5, 4'd4, 1, 0, 4'h3,  6, 1,  0, 0, 0, 4'h0, 0,  0, -1};
    vt[10] = '{4'h9, 7'd5, 4'd0, 1, 0, 4'h3,  6, 1,  0, 0, 0, 4'h0, 0,  0, -1};
    vt[11] = '{4'h1, 7'd5, 4'd3, 1, 0, 4'h3,  6, 0,  0, 1, 0, 4'h0, 0,  4,  3};
    vt[12] = '{4'h1, 7'd5, 4'd3, 1, 0, 4'h3, 67, 1,  0, 1, 0, 4'h0, 0, 64,  3};
    vt[13] = '{4'h1, 7'd5, 4'd3, 1, 0, 4'h3,  2, 1,  1, 0, 1, 4'h2, 0,  0,  3};
    vt[14] = '{4'hD, 7'd5, 4'd0, 1, 0, 4'hB,  6, 1,  0, 1, 0, 4'h0, 0,  4,  0};
    vt[15] = '{4'h1, 7'd5, 4'd1, 1, 0, 4'h1,  6, 1,  0, 1, 0, 4'h0, 0,  4,  1};
    vt[16] = '{4'h1, 7'd5, 4'd3, 1, 0, 4'hB, 66, 1,  1, 0, 1, 4'h2, 0, 64,  3};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs",
          int'({ep_num, ep_data_put, ep_data, ep_commit, ep_abort, ep_setup, hs_req, hs_pid}), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      logic [7:0] base;
      int ok;
      base = 8'(i * 16 + 1);
      run_txn(vt[i].tpid, vt[i].addr, vt[i].endp, vt[i].rdy, vt[i].stl,
              vt[i].dpid, vt[i].nb, vt[i].dval, base, 4'h0);
      check($sformatf("v%0d_commit", i), c_commit, vt[i].ec);
      check($sformatf("v%0d_abort", i), c_abort, vt[i].ea);
      check($sformatf("v%0d_hs", i), c_hs, vt[i].eh);
      if (vt[i].eh != 0) check($sformatf("v%0d_hs_pid", i), int'(last_pid), int'(vt[i].epid));
      check($sformatf("v%0d_setup", i), c_setup, vt[i].es);
      check($sformatf("v%0d_nbytes", i), got.size(), vt[i].enb);
      ok = 1;
      for (int k = 0; k < got.size() && k < vt[i].enb; k++)
        if (got[k] != 8'(int'(base) + k)) ok = 0;
      check($sformatf("v%0d_bytes", i), ok, 1);
      if (vt[i].epn >= 0) check($sformatf("v%0d_ep_num", i), int'(ep_num), vt[i].epn);
    end
    // toggles now: ep0=0 ep1=0 ep2=1 ep3=0

    // toggle_clr after SETUP returns ep0 to DATA0
    run_txn(4'hD, 7'd5, 4'd0, 1, 0, 4'h3, 6, 1, 8'h40, 4'h0);
    check("clr_setup_commit", c_commit, 1);
    toggle_clr = 4'b0001;
    @(negedge clk);
    toggle_clr = 4'b0000;
    run_txn(4'h1, 7'd5, 4'd0, 1, 0, 4'h3, 6, 1, 8'h50, 4'h0);
    check("clr_then_data0_commit", c_commit, 1);

    // toggle_clr coincident with the flip on ep1 wins
    run_txn(4'h1, 7'd5, 4'd1, 1, 0, 4'h3, 6, 1, 8'h60, 4'b0010);
    check("clr_race_commit", c_commit, 1);
    run_txn(4'h1, 7'd5, 4'd1, 1, 0, 4'h3, 6, 1, 8'h70, 4'h0);
    check("clr_race_wins", c_commit, 1);
    // ep1 toggle now 1

    // Data start on the exact timeout cycle still wins
    ep_ready = 4'hF; ep_stall = 4'h0;
    clear_mon();
    token(4'h1, 7'd5, 4'd3);
    repeat (255) @(negedge clk);
    data_pkt(4'h3, 6, 1, 8'h80, 4'h0);
    repeat (4) @(negedge clk);
    check("tmo_edge_commit", c_commit, 1);
    // ep3 toggle now 1

    // One cycle later the token has expired
    clear_mon();
    token(4'h1, 7'd5, 4'd3);
    repeat (256) @(negedge clk);
    data_pkt(4'hB, 6, 1, 8'h90, 4'h0);
    repeat (4) @(negedge clk);
    check("tmo_expired_events", c_commit + c_abort + c_hs + got.size(), 0);

    // Reset while a handshake waits for acceptance
    hs_ack = 1'b0;
    run_txn(4'h1, 7'd5, 4'd3, 1, 0, 4'hB, 6, 1, 8'hA0, 4'h0);
    check("hold_commit", c_commit, 1);
    check("hold_hs_req", int'(hs_req), 1);
    repeat (3) @(negedge clk);
    check("hold_hs_req_later", int'(hs_req), 1);
    check("hold_hs_pid", int'(hs_pid), 2);
    #2 reset_n = 1'b0;
    #1 check("reset_drops_hs_req", int'(hs_req), 0);
    check("reset_no_pulse", int'({ep_commit, ep_abort}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    hs_ack = 1'b1;
    @(negedge clk);
    // Toggles cleared by reset: ep1 expects DATA0 again
    run_txn(4'h1, 7'd5, 4'd1, 1, 0, 4'h3, 6, 1, 8'hB0, 4'h0);
    check("post_reset_commit", c_commit, 1);
    check("post_reset_abort", c_abort, 0);

    check("commit_abort_exclusive", c_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_fs_out_sequencer.md
# usb_fs_out_sequencer

Sequences the USB full-speed receive path for OUT and SETUP transactions. It sits between the receive decoder's `clk`-domain outputs and the OUT endpoint buffers. It matches tokens against the device address, steers the following data packet to one of `NUM_EP` endpoints, strips the CRC16 bytes, tracks per-endpoint data toggles, and issues one ACK/NAK/STALL handshake request to the transmit side per transaction.

## Interface
- `NUM_EP`, 4: number of OUT endpoints (0..NUM_EP-1); a token for any higher endpoint is ignored.
- `MAX_PKT`, 64: maximum payload bytes per data packet, CRC excluded.
- `TIMEOUT_CYC`, 255: `clk` cycles to wait after a token for the data packet's `rx_pkt_start`.

- `clk` in 1: single clock; all ports are synchronous to it.
- `reset_n` in 1: asynchronous, active-low reset.
- `dev_addr` in 7: currently assigned device address.
- `rx_pkt_start` in 1: one-cycle pulse at the start of a received packet.
- `rx_pkt_end` in 1: one-cycle pulse at the end of a received packet; `rx_pid`/`rx_addr`/`rx_endp` are valid in this cycle.
- `rx_pid` in 4, `rx_addr` in 7, `rx_endp` in 4: fields of the packet that just ended.
- `rx_valid_packet` in 1: level; PID and CRC checks pass, valid at `rx_pkt_end`.
- `rx_data_put` in 1, `rx_data` in 8: received byte strobe and byte; the stream includes the 2 CRC16 bytes.
- `ep_ready` in NUM_EP: endpoint has room for a full `MAX_PKT` packet.
- `ep_stall` in NUM_EP: endpoint is halted.
- `toggle_clr` in NUM_EP: forces the expected toggle of that endpoint to DATA0.
- `ep_num` out 4: target endpoint; valid from token acceptance through `ep_commit`/`ep_abort`.
- `ep_data_put` out 1, `ep_data` out 8: payload byte write to the endpoint.
- `ep_commit` out 1: pulse; the written bytes form a good packet.
- `ep_abort` out 1: pulse; discard the bytes written since the token.
- `ep_setup` out 1: qualifies `ep_commit`; set when the packet was SETUP data.
- `hs_req` out 1, `hs_pid` out 4: handshake request to the transmit side; ACK=0010, NAK=1010, STALL=1110.
- `hs_ack` in 1: transmit side accepts; transfer occurs on a cycle where `hs_req && hs_ack`.

## Operation
- **States:** IDLE, WAIT_DATA, DATA, HANDSHAKE.
- **IDLE**
  - Token acceptance at `rx_pkt_end` requires all of:
    - `rx_valid_packet`
    - `rx_pid` is OUT (0001) or SETUP (1101)
    - `rx_addr == dev_addr`
    - `rx_endp < NUM_EP`
  - On acceptance: latch endpoint, is_setup flag, `ep_ready[ep]` and `ep_stall[ep]`; clear the timeout counter; go to WAIT_DATA.
  - All other packets are ignored.
- **WAIT_DATA**
  - `rx_pkt_start` → DATA; clear the byte counter and the CRC-strip pipeline.
  - Counter reaching `TIMEOUT_CYC` → IDLE, with no pulses and no handshake.
- **DATA**
  - Each `rx_data_put` pushes the byte into a 2-deep pipeline.
  - When the pipeline already holds 2 bytes, the oldest byte is emitted on `ep_data`.
  - CRC bytes therefore never reach the endpoint.
  - Byte counter saturates. Once it exceeds `MAX_PKT+2`, set the overflow flag and stop emitting bytes.
- **Decision at `rx_pkt_end` in DATA**, first matching rule wins:
  1. `!rx_valid_packet`, or PID is not DATA0 (0011)/DATA1 (1011), or overflow → abort, no handshake, IDLE.
  2. SETUP with DATA1 → abort, no handshake.
  3. SETUP with DATA0 → commit with `ep_setup=1`, ACK, toggle[ep] := 1. `ep_ready` and `ep_stall` are ignored for SETUP.
  4. Stalled → abort, STALL.
  5. Not ready → abort, NAK.
  6. PID toggle ≠ toggle[ep] (duplicate packet) → abort, ACK, toggle unchanged.
  7. Otherwise → commit, ACK, toggle[ep] flips.
- **HANDSHAKE**
  - Hold `hs_req=1` and `hs_pid` stable until the `hs_req && hs_ack` cycle, then go to IDLE.
  - `rx_pkt_start`/`rx_pkt_end` arriving in HANDSHAKE are ignored.
- **Toggles:** one bit per endpoint; 0 = DATA0.
  - `toggle_clr` wins over a simultaneous toggle update to the same endpoint.

## Timing
- **Reset values:** all outputs 0, state IDLE, all toggles 0, counters and pipeline cleared.
- **Data latency:** `ep_data_put` is registered and asserts 1 cycle after the `rx_data_put` that pushes a byte out of the pipeline.
- **Decision latency:** `ep_commit`/`ep_abort` pulse for exactly 1 cycle, 1 cycle after `rx_pkt_end`. `hs_req` rises in that same cycle.
- **Fastest handshake:** `hs_ack` tied high gives a 1-cycle `hs_req`, then IDLE the following cycle.
- **Exclusivity:** `ep_commit` and `ep_abort` are never asserted together. Exactly one of them follows every DATA-state `rx_pkt_end`; neither follows a timeout.
- **Timeout boundary:** `rx_pkt_start` in the same cycle the counter hits `TIMEOUT_CYC` → DATA (start wins).
- **Short packet:** a data packet with ≤2 bytes emits no `ep_data_put`; a valid one commits a zero-length packet.
- **Reset mid-transaction:** `reset_n` low in any state returns to IDLE immediately. Any pending `hs_req` drops and no commit/abort is emitted.

## Test plan
- **Normal OUT:** `dev_addr`=5; OUT addr 5 ep 1, then DATA0 with 4 payload + 2 CRC bytes, valid, ready → 4 `ep_data_put` in order, `ep_commit`, `hs_pid`=0010, toggle[1]=1.
- **Duplicate:** repeat the same DATA0 to ep 1 → 4 bytes written, `ep_abort`, ACK, toggle[1] stays 1.
- **Stall / not ready:** ep 2 with `ep_stall`=1 → abort + 1110; ep 2 with stall=0, `ep_ready`=0 → abort + 1010; toggle unchanged in both cases.
- **SETUP:** SETUP ep 0 + DATA0 8 bytes with `ep_stall[0]`=1 → commit, `ep_setup`=1, ACK, toggle[0]=1; `toggle_clr[0]` pulse → toggle[0]=0.
- **Rejected tokens:** OUT to addr 6, or ep ≥ `NUM_EP` → no outputs. Valid token with no data for 255 cycles → return to IDLE silently.
- **Errors and reset:** bad CRC data packet → abort, no `hs_req`. 67-byte data packet → 64 bytes emitted, abort, no handshake. `reset_n` low while `hs_req` is pending with `hs_ack`=0 → `hs_req`=0 at once.
